// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants, FSM state type, neighbour slot table and
// window address helper for the Local Binary Pattern engine.
// Optional build macro used by the top: LBP_WINDOW_REUSE_EN.
package lbp_pkg;

   localparam int IMG_W  = 128;
   localparam int IMG_H  = 128;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = ADDR_W - COL_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CALC,
      ST_WRITE,
      ST_DONE
   } state_t;

   // The 3x3 window is stored row-major in slots 0..8 with the centre in
   // slot 4. Entry i gives the slot holding neighbour g_i.
   localparam int CENTRE_SLOT = 4;
   localparam logic [3:0] NB_SLOT [8] = '{4'd0, 4'd1, 4'd2, 4'd3,
                                          4'd5, 4'd6, 4'd7, 4'd8};

   // Address of window element (fr, fc) around centre (row, col); fr/fc are
   // 0..2, so the pixel lies at (row+fr-1, col+fc-1). IMG_W is a power of
   // two, so the address is just the concatenation of row and column.
   function automatic logic [ADDR_W-1:0] win_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col,
                                                  input logic [1:0]       fr,
                                                  input logic [1:0]       fc);
      logic [ROW_W-1:0] r;
      logic [COL_W-1:0] c;
      r = row + ROW_W'(fr) - ROW_W'(1);
      c = col + COL_W'(fc) - COL_W'(1);
      return {r, c};
   endfunction

endpackage

// File: rtl/lbp_code.sv
// lbp_code: combinational LBP code generator.
// Ports:
//   centre  in   DATA_W     centre pixel value
//   nbrs    in   8*DATA_W   neighbours, g_i at bits [i*DATA_W +: DATA_W]
//   code    out  DATA_W     bit i = (g_i >= centre), unsigned compare
module lbp_code
   import lbp_pkg::*;
(
   input  logic [DATA_W-1:0]   centre,
   input  logic [8*DATA_W-1:0] nbrs,
   output logic [DATA_W-1:0]   code
);

   for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
      assign code[gi] = (nbrs[gi*DATA_W +: DATA_W] >= centre);
   end

endmodule

// File: rtl/lbp.sv
// lbp: Local Binary Pattern engine. Reads a grayscale frame from an external
// zero-wait memory and writes one LBP code per interior pixel, in raster order.
// Ports:
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous, active-low reset
//   gray_ready  in   1       source memory ready; frame starts when high
//   gray_req    out  1       read request
//   gray_addr   out  ADDR_W  read address (row*IMG_W + col)
//   gray_data   in   DATA_W  read data, sampled at the posedge ending the request cycle
//   lbp_valid   out  1       one-cycle write strobe per code
//   lbp_addr    out  ADDR_W  centre pixel address
//   lbp_data    out  DATA_W  LBP code
//   finish      out  1       frame complete, held until reset
// Parameter FRAME_H (default IMG_H) sets the number of image rows.
// Build macro LBP_WINDOW_REUSE_EN: keep the 3x3 window across a row and fetch
// only the new right-hand column when stepping right. Without it every centre
// fetches all nine pixels. Results are identical; only the cycle count differs.
module lbp
   import lbp_pkg::*;
#(
   parameter int FRAME_H = IMG_H
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [DATA_W-1:0] gray_data,
   output logic              lbp_valid,
   output logic [ADDR_W-1:0] lbp_addr,
   output logic [DATA_W-1:0] lbp_data,
   output logic              finish
);

`ifdef LBP_WINDOW_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_H - 2);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 2);

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d, nxt_row;
   logic [COL_W-1:0]  col_q, col_d, nxt_col;
   logic [1:0]        fr_q, fr_d, fc_q, fc_d;
   logic [DATA_W-1:0] win_q [9];
   logic [DATA_W-1:0] win_d [9];
   logic              gray_req_q, gray_req_d;
   logic [ADDR_W-1:0] gray_addr_q, gray_addr_d;
   logic              lbp_valid_q, lbp_valid_d;
   logic [ADDR_W-1:0] lbp_addr_q, lbp_addr_d;
   logic [DATA_W-1:0] lbp_data_q, lbp_data_d;
   logic              finish_q, finish_d;
   logic [3:0]        slot;
   logic              partial;

   logic [8*DATA_W-1:0] nbrs;
   logic [DATA_W-1:0]   code;

   for (genvar gi = 0; gi < 8; gi++) begin : g_nbr
      assign nbrs[gi*DATA_W +: DATA_W] = win_q[NB_SLOT[gi]];
   end

   lbp_code u_code (
      .centre (win_q[CENTRE_SLOT]),
      .nbrs   (nbrs),
      .code   (code)
   );

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      fr_d        = fr_q;
      fc_d        = fc_q;
      win_d       = win_q;
      gray_req_d  = gray_req_q;
      gray_addr_d = gray_addr_q;
      lbp_valid_d = 1'b0;
      lbp_addr_d  = lbp_addr_q;
      lbp_data_d  = lbp_data_q;
      finish_d    = finish_q;
      nxt_row     = row_q;
      nxt_col     = col_q;
      slot        = 4'(fr_q) * 4'd3 + 4'(fc_q);
      // Away from the row start only the right-hand column (fc==2) is fetched.
      partial     = REUSE && (col_q != COL_W'(1));

      case (state_q)
         ST_IDLE: begin
            if (gray_ready) begin
               state_d     = ST_FETCH;
               row_d       = ROW_W'(1);
               col_d       = COL_W'(1);
               fr_d        = 2'd0;
               fc_d        = 2'd0;
               gray_req_d  = 1'b1;
               gray_addr_d = win_addr(ROW_W'(1), COL_W'(1), 2'd0, 2'd0);
            end
         end

         ST_FETCH: begin
            // The request shown this cycle is answered now; store it in its slot.
            win_d[slot] = gray_data;
            if (fr_q == 2'd2 && fc_q == 2'd2) begin
               gray_req_d  = 1'b0;
               gray_addr_d = '0;
               state_d     = ST_CALC;
            end else begin
               if (fc_q == 2'd2) begin
                  fr_d = fr_q + 2'd1;
                  fc_d = partial ? 2'd2 : 2'd0;
               end else begin
                  fc_d = fc_q + 2'd1;
               end
               gray_addr_d = win_addr(row_q, col_q, fr_d, fc_d);
            end
         end

         ST_CALC: begin
            lbp_valid_d = 1'b1;
            lbp_addr_d  = {row_q, col_q};
            lbp_data_d  = code;
            state_d     = ST_WRITE;
         end

         ST_WRITE: begin
            if (row_q == LAST_ROW && col_q == LAST_COL) begin
               state_d  = ST_DONE;
               finish_d = 1'b1;
            end else begin
               if (col_q == LAST_COL) begin
                  nxt_row = row_q + ROW_W'(1);
                  nxt_col = COL_W'(1);
               end else begin
                  nxt_col = col_q + COL_W'(1);
               end
               row_d = nxt_row;
               col_d = nxt_col;
               fr_d  = 2'd0;
               if (REUSE && nxt_col != COL_W'(1)) begin
                  // Slide the window left; column 2 is refetched.
                  for (int r = 0; r < 3; r++) begin
                     win_d[r*3]     = win_q[r*3 + 1];
                     win_d[r*3 + 1] = win_q[r*3 + 2];
                  end
                  fc_d = 2'd2;
               end else begin
                  fc_d = 2'd0;
               end
               gray_req_d  = 1'b1;
               gray_addr_d = win_addr(nxt_row, nxt_col, 2'd0, fc_d);
               state_d     = ST_FETCH;
            end
         end

         ST_DONE: begin
            finish_d = 1'b1;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         fr_q        <= '0;
         fc_q        <= '0;
         gray_req_q  <= 1'b0;
         gray_addr_q <= '0;
         lbp_valid_q <= 1'b0;
         lbp_addr_q  <= '0;
         lbp_data_q  <= '0;
         finish_q    <= 1'b0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         fr_q        <= fr_d;
         fc_q        <= fc_d;
         gray_req_q  <= gray_req_d;
         gray_addr_q <= gray_addr_d;
         lbp_valid_q <= lbp_valid_d;
         lbp_addr_q  <= lbp_addr_d;
         lbp_data_q  <= lbp_data_d;
         finish_q    <= finish_d;
         for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
      end
   end

   assign gray_req  = gray_req_q;
   assign gray_addr = gray_addr_q;
   assign lbp_valid = lbp_valid_q;
   assign lbp_addr  = lbp_addr_q;
   assign lbp_data  = lbp_data_q;
   assign finish    = finish_q;

endmodule

// File: tb/tb_lbp.sv
// tb_lbp: directed + randomized bench for lbp on a short frame (128 x 7).
// A behavioural model derives every expected code from the gray image.
module tb_lbp;
   import lbp_pkg::*;

   localparam int H     = 7;
   localparam int W     = IMG_W;
   localparam int NPIX  = W * H;
   localparam int NCODE = (W - 2) * (H - 2);

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              gray_ready = 1'b0;
   logic              gray_req;
   logic [ADDR_W-1:0] gray_addr;
   logic [DATA_W-1:0] gray_data;
   logic              lbp_valid;
   logic [ADDR_W-1:0] lbp_addr;
   logic [DATA_W-1:0] lbp_data;
   logic              finish;

   lbp #(.FRAME_H(H)) dut (
      .clk        (clk),
      .reset      (reset),
      .gray_ready (gray_ready),
      .gray_req   (gray_req),
      .gray_addr  (gray_addr),
      .gray_data  (gray_data),
      .lbp_valid  (lbp_valid),
      .lbp_addr   (lbp_addr),
      .lbp_data   (lbp_data),
      .finish     (finish)
   );

   always #5 clk = ~clk;

   logic [7:0] gray [NPIX];
   logic [7:0] res  [NPIX];

   assign gray_data = (gray_req && int'(gray_addr) < NPIX) ? gray[gray_addr] : 8'hxx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int wcount, order_err, post_err, first_addr, last_wr_cyc, fin_cyc, req_count;
   bit fin_seen;

   int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
   int dc [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

   always @(posedge clk) cyc++;

   // Write-side store: captures codes at negedge and tracks order/timing.
   always @(negedge clk) begin
      if (gray_req) req_count++;
      if (lbp_valid) begin
         int ea;
         ea = (1 + wcount / (W - 2)) * W + 1 + wcount % (W - 2);
         if (wcount == 0) first_addr = int'(lbp_addr);
         if (int'(lbp_addr) != ea) order_err++;
         if (int'(lbp_addr) < NPIX) res[lbp_addr] = lbp_data;
         wcount++;
         last_wr_cyc = cyc;
      end
      if (finish && !fin_seen) begin
         fin_seen = 1'b1;
         fin_cyc  = cyc;
      end
      if (finish && (lbp_valid || gray_req)) post_err++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_code(input int r, input int c);
      int v;
      v = 0;
      for (int i = 0; i < 8; i++)
         if (gray[(r + dr[i]) * W + c + dc[i]] >= gray[r * W + c]) v += (1 << i);
      return v;
   endfunction

   task automatic clear_state();
      for (int i = 0; i < NPIX; i++) res[i] = 8'h00;
      wcount = 0; order_err = 0; post_err = 0; first_addr = -1;
      last_wr_cyc = 0; fin_cyc = 0; fin_seen = 1'b0; req_count = 0;
   endtask

   // Reset pulse, optional idle hold with gray_ready low, then start.
   task automatic start_frame(input int hold);
      @(negedge clk);
      reset = 1'b0;
      gray_ready = 1'b0;
      @(negedge clk);
      clear_state();
      reset = 1'b1;
      repeat (hold) @(negedge clk);
      if (hold > 0) check("idle_no_req", 32'(req_count), 32'd0);
      gray_ready = 1'b1;
   endtask

   task automatic finish_frame(input string tag);
      int mism;
      for (int i = 0; i < 20000 && !finish; i++) @(negedge clk);
      check({tag, "_finish"}, 32'(finish), 32'd1);
      repeat (4) @(negedge clk);
      mism = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            int e;
            e = (r == 0 || c == 0 || r == H - 1 || c == W - 1) ? 0 : ref_code(r, c);
            if (int'(res[r * W + c]) != e) mism++;
         end
      check({tag, "_mem_mismatch"}, 32'(mism), 32'd0);
      check({tag, "_wcount"}, 32'(wcount), 32'(NCODE));
      check({tag, "_order"}, 32'(order_err), 32'd0);
      check({tag, "_first_addr"}, 32'(first_addr), 32'd129);
      check({tag, "_finish_lat"}, 32'(fin_cyc - last_wr_cyc), 32'd1);
      check({tag, "_quiet_after"}, 32'(post_err), 32'd0);
      $display("frame %s: writes=%0d", tag, wcount);
   endtask

   initial begin
      clear_state();
      for (int i = 0; i < NPIX; i++) gray[i] = 8'h00;

      // Reset state
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gray_req", 32'(gray_req), 32'd0);
      check("rst_gray_addr", 32'(gray_addr), 32'd0);
      check("rst_lbp_valid", 32'(lbp_valid), 32'd0);
      check("rst_lbp_addr", 32'(lbp_addr), 32'd0);
      check("rst_finish", 32'(finish), 32'd0);

      // All-zero frame
      start_frame(0);
      finish_frame("zero");
      check("zero_129", 32'(res[129]), 32'hFF);
      check("zero_border0", 32'(res[0]), 32'd0);

      // Ramp
      for (int i = 0; i < NPIX; i++) gray[i] = 8'(i % 256);
      start_frame(0);
      finish_frame("ramp");
      check("ramp_129", 32'(res[129]), 32'h10);

      // Flat 100 with a dip at (5,5), gray_ready held low for 20 cycles
      for (int i = 0; i < NPIX; i++) gray[i] = 8'd100;
      gray[5 * W + 5] = 8'd50;
      start_frame(20);
      finish_frame("dip");
      check("dip_645", 32'(res[645]), 32'hFF);
      check("dip_516", 32'(res[516]), 32'h7F);

      // Random frame interrupted by reset, then rerun to completion
      for (int i = 0; i < NPIX; i++) gray[i] = 8'($urandom_range(0, 255));
      start_frame(0);
      for (int i = 0; i < 20000 && wcount < 300; i++) @(negedge clk);
      check("mid_progress", 32'(wcount >= 300), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_gray_req", 32'(gray_req), 32'd0);
      check("mid_rst_lbp_valid", 32'(lbp_valid), 32'd0);
      check("mid_rst_lbp_addr", 32'(lbp_addr), 32'd0);
      check("mid_rst_lbp_data", 32'(lbp_data), 32'd0);
      check("mid_rst_finish", 32'(finish), 32'd0);
      clear_state();
      reset = 1'b1;
      finish_frame("restart");

      // Random frame with few grey levels, so equal neighbours are common
      for (int i = 0; i < NPIX; i++) gray[i] = 8'($urandom_range(0, 3));
      start_frame(3);
      finish_frame("lowrange");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
